// File: rtl/hdmi_source_sequencer_if.sv
// ---------------------------------------------------------------------------
// hdmi_source_sequencer_if
//
// Purpose: one VGA-timing video bus (colour plus sync/blank) in the pixel
// clock domain. It carries a source into the sequencer or the sequenced
// stream out to the serializer.
//
// Handshake: there is no valid/ready flow control. The bus carries exactly
// one pixel per clk_pixel cycle, and the receiver samples it on every rising
// edge. The master drives all fields and the slave only reads them.
//
// Signals:
//   r, g, b  C_depth bits each  colour channels
//   hsync    1                  horizontal sync
//   vsync    1                  vertical sync (its rising edge marks a frame)
//   blank    1                  1 = outside the active video area
//
// Modports: master (drives the bus), slave (samples the bus).
// ---------------------------------------------------------------------------
interface hdmi_source_sequencer_if #(
  parameter int C_depth = 3
);
  logic [C_depth-1:0] r;
  logic [C_depth-1:0] g;
  logic [C_depth-1:0] b;
  logic               hsync;
  logic               vsync;
  logic               blank;

  modport master (output r, g, b, hsync, vsync, blank);
  modport slave  (input  r, g, b, hsync, vsync, blank);
endinterface

// File: rtl/hdmi_source_sequencer.sv
// ---------------------------------------------------------------------------
// hdmi_source_sequencer
//
// Purpose: a pixel-clock controller placed between two VGA-timing sources
// and the vga2hdmi_sdr serializer.
//   - It keeps the link blanked until PLL lock has been stable for
//     C_lock_cycles cycles, and then for C_settle_frames more frames.
//   - It switches between the two sources only on a frame edge of the
//     current source, and only after a button request.
//   - Every output is registered.
//
// Ports:
//   clk_pixel   in   pixel clock; the only clock
//   resetn      in   synchronous, active-low reset
//   locked      in   PLL lock, asynchronous; passes through a 2-FF synchronizer
//   sel_req     in   raw button; each accepted rising edge requests a toggle
//   src0, src1  in   source video buses (slave modport)
//   out         out  video bus to the serializer (master modport)
//   active_src  out  currently selected source
//   link_up     out  1 only in RUN
//   dbg_state   out  FSM state (0 = WAIT_LOCK, 1 = SETTLE, 2 = RUN)
//
// Configuration macro: HDMI_SEQ_DEBOUNCE_EN
//   - Defined: the synced sel_req must hold a new level for
//     2^C_debounce_bits consecutive cycles before that level is accepted.
//   - Undefined (the default): the synced sel_req is edge-detected directly.
// ---------------------------------------------------------------------------
module hdmi_source_sequencer #(
  parameter int C_depth         = 3,
  parameter int C_lock_cycles   = 1024,
  parameter int C_settle_frames = 2,
  parameter int C_debounce_bits = 16
) (
  input  logic                            clk_pixel,
  input  logic                            resetn,
  input  logic                            locked,
  input  logic                            sel_req,
  hdmi_source_sequencer_if.slave          src0,
  hdmi_source_sequencer_if.slave          src1,
  hdmi_source_sequencer_if.master         out,
  output logic                            active_src,
  output logic                            link_up,
  output logic [1:0]                      dbg_state
);

  localparam int LW = $clog2(C_lock_cycles + 1);
  localparam int FW = $clog2(C_settle_frames + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(C_lock_cycles - 1);
  localparam logic [FW-1:0] SETTLE_N  = FW'(C_settle_frames);
  localparam logic [FW-1:0] FRAME_MAX = '1;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Synchronizers
  logic r_lock_meta, r_lock_sync;
  logic r_sel_meta,  r_sel_sync;

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_sel_meta  <= 1'b0;
      r_sel_sync  <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_sync <= r_lock_meta;
      r_sel_meta  <= sel_req;
      r_sel_sync  <= r_sel_meta;
    end
  end

  // Request edge detection
  logic w_req_edge;

`ifdef HDMI_SEQ_DEBOUNCE_EN
  logic [C_debounce_bits-1:0] r_db_cnt;
  logic                       r_sel_stable;
  logic                       w_db_done;

  // The counter runs only while the synced input differs from the accepted
  // level. With a single bit, "differs" always means "the same new level", so
  // a return to the old level restarts the count.
  assign w_db_done  = (r_sel_sync != r_sel_stable) && (r_db_cnt == '1);
  assign w_req_edge = w_db_done && r_sel_sync;

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      r_db_cnt     <= '0;
      r_sel_stable <= 1'b0;
    end else if (r_sel_sync == r_sel_stable) begin
      r_db_cnt <= '0;
    end else if (w_db_done) begin
      r_sel_stable <= r_sel_sync;
      r_db_cnt     <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + C_debounce_bits'(1);
    end
  end
`else
  logic r_sel_prev;

  assign w_req_edge = r_sel_sync & ~r_sel_prev;

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      r_sel_prev <= 1'b0;
    end else begin
      r_sel_prev <= r_sel_sync;
    end
  end
`endif

  // Sequencer state
  state_t             r_state;
  logic [LW-1:0]      r_lock_cnt;
  logic [FW-1:0]      r_frame_cnt;
  logic               r_active;
  logic               r_req_pending;
  logic               r_vs_prev;
  logic [C_depth-1:0] r_out_r, r_out_g, r_out_b;
  logic               r_out_hs, r_out_vs, r_out_blank;
  logic               r_link_up;

  state_t             w_state_nxt;
  logic               w_toggle;
  logic               w_active_nxt;
  logic               w_vs_now;
  logic               w_frame_edge;
  logic [FW-1:0]      w_frame_inc;
  logic [C_depth-1:0] w_sel_r, w_sel_g, w_sel_b;
  logic               w_sel_hs, w_sel_vs, w_sel_blank;

  // The frame edge is taken from the source selected in this cycle.
  assign w_vs_now     = r_active ? src1.vsync : src0.vsync;
  assign w_frame_edge = w_vs_now & ~r_vs_prev;
  assign w_frame_inc  = (r_frame_cnt == FRAME_MAX) ? r_frame_cnt
                                                   : r_frame_cnt + FW'(1);
  assign w_active_nxt = r_active ^ w_toggle;

  // The output mux follows the next selection. The switch therefore shows on
  // the output one cycle after the frame edge, and vs_prev loads the new
  // source's vsync, so the new source cannot produce a false frame edge.
  assign w_sel_r     = w_active_nxt ? src1.r     : src0.r;
  assign w_sel_g     = w_active_nxt ? src1.g     : src0.g;
  assign w_sel_b     = w_active_nxt ? src1.b     : src0.b;
  assign w_sel_hs    = w_active_nxt ? src1.hsync : src0.hsync;
  assign w_sel_vs    = w_active_nxt ? src1.vsync : src0.vsync;
  assign w_sel_blank = w_active_nxt ? src1.blank : src0.blank;

  always_comb begin
    w_state_nxt = r_state;
    w_toggle    = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: if (r_lock_cnt == LOCK_LAST) w_state_nxt = ST_SETTLE;
      ST_SETTLE:    if (w_frame_edge && (w_frame_inc >= SETTLE_N)) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (r_req_pending && w_frame_edge) begin
          w_toggle    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      default:      w_state_nxt = ST_WAIT_LOCK;
    endcase
    // Loss of lock overrides everything else, including a pending toggle.
    if (!r_lock_sync) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_toggle    = 1'b0;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      r_state       <= ST_WAIT_LOCK;
      r_lock_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_active      <= 1'b0;
      r_req_pending <= 1'b0;
      r_vs_prev     <= 1'b0;
      r_out_r       <= '0;
      r_out_g       <= '0;
      r_out_b       <= '0;
      r_out_hs      <= 1'b0;
      r_out_vs      <= 1'b0;
      r_out_blank   <= 1'b1;
      r_link_up     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_active  <= w_active_nxt;
      r_vs_prev <= w_sel_vs;
      r_link_up <= (w_state_nxt == ST_RUN);

      // A request that arrives in the same cycle as a toggle arms the next switch.
      if (w_req_edge) begin
        r_req_pending <= 1'b1;
      end else if (w_toggle) begin
        r_req_pending <= 1'b0;
      end

      if (!r_lock_sync || (r_state != ST_WAIT_LOCK) || (r_lock_cnt == LOCK_LAST)) begin
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + LW'(1);
      end

      if (w_toggle || ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_SETTLE))) begin
        r_frame_cnt <= '0;
      end else if ((r_state == ST_SETTLE) && w_frame_edge) begin
        r_frame_cnt <= w_frame_inc;
      end

      // While the link is forced blank, sync still passes through so the
      // monitor stays locked to the timing.
      r_out_hs <= w_sel_hs;
      r_out_vs <= w_sel_vs;
      if (w_state_nxt == ST_RUN) begin
        r_out_r     <= w_sel_r;
        r_out_g     <= w_sel_g;
        r_out_b     <= w_sel_b;
        r_out_blank <= w_sel_blank;
      end else begin
        r_out_r     <= '0;
        r_out_g     <= '0;
        r_out_b     <= '0;
        r_out_blank <= 1'b1;
      end
    end
  end

  assign out.r      = r_out_r;
  assign out.g      = r_out_g;
  assign out.b      = r_out_b;
  assign out.hsync  = r_out_hs;
  assign out.vsync  = r_out_vs;
  assign out.blank  = r_out_blank;
  assign active_src = r_active;
  assign link_up    = r_link_up;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_hdmi_source_sequencer.sv
module tb_hdmi_source_sequencer;

  localparam int DEPTH    = 3;
  localparam int LOCK_N   = 16;
  localparam int SETTLE_N = 2;
  localparam int DB_BITS  = 4;
  localparam int OW       = 3 * DEPTH + 5;
  localparam int P0       = 64;   // src0 frame length in cycles
  localparam int P1       = 120;  // src1 frame length in cycles
  localparam int M_WAIT   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_RUN    = 2;
  localparam logic [OW-1:0] RESET_VEC = OW'(4);  // only out_blank set

  // Clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic locked = 1'b0;
  logic sel_req = 1'b0;
  logic active_src, link_up;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  hdmi_source_sequencer_if #(.C_depth(DEPTH)) src0_if ();
  hdmi_source_sequencer_if #(.C_depth(DEPTH)) src1_if ();
  hdmi_source_sequencer_if #(.C_depth(DEPTH)) out_if ();

  hdmi_source_sequencer #(
    .C_depth(DEPTH), .C_lock_cycles(LOCK_N),
    .C_settle_frames(SETTLE_N), .C_debounce_bits(DB_BITS)
  ) dut (
    .clk_pixel(clk), .resetn(resetn), .locked(locked), .sel_req(sel_req),
    .src0(src0_if.slave), .src1(src1_if.slave), .out(out_if.master),
    .active_src(active_src), .link_up(link_up), .dbg_state(dbg_state)
  );

  // Scoreboard
  logic [OW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] pack(input logic [DEPTH-1:0] r, g, b,
                                         input logic hs, vs, bl, act, lu);
    return {r, g, b, hs, vs, bl, act, lu};
  endfunction

  function automatic logic [OW-1:0] dut_vec();
    return pack(out_if.r, out_if.g, out_if.b, out_if.hsync, out_if.vsync,
                out_if.blank, active_src, link_up);
  endfunction

  // Reference model state
  logic m_meta_l, m_sync_l, m_meta_s, m_sync_s, m_sel_prev, m_stable;
  logic m_active, m_pend, m_vs_prev;
  int   m_state, m_lock_cnt, m_frame, m_db_cnt;

  task automatic model_step();
    logic vs_now, fedge, req_edge, toggle;
    int   nstate;
    if (!resetn) begin
      m_meta_l = 0; m_sync_l = 0; m_meta_s = 0; m_sync_s = 0;
      m_sel_prev = 0; m_stable = 0; m_db_cnt = 0;
      m_state = M_WAIT; m_lock_cnt = 0; m_frame = 0;
      m_active = 0; m_pend = 0; m_vs_prev = 0;
      exp_q.push_back(RESET_VEC);
      return;
    end
    vs_now = m_active ? src1_if.vsync : src0_if.vsync;
    fedge  = vs_now && !m_vs_prev;
`ifdef HDMI_SEQ_DEBOUNCE_EN
    req_edge = 0;
    if (m_sync_s == m_stable) m_db_cnt = 0;
    else if (m_db_cnt == (1 << DB_BITS) - 1) begin
      m_stable = m_sync_s; m_db_cnt = 0; req_edge = m_sync_s;
    end else m_db_cnt++;
`else
    req_edge = m_sync_s && !m_sel_prev;
`endif
    m_sel_prev = m_sync_s;
    toggle = 0;
    nstate = m_state;
    if (!m_sync_l) begin
      nstate = M_WAIT; m_lock_cnt = 0;
    end else begin
      case (m_state)
        M_WAIT: begin
          if (m_lock_cnt == LOCK_N - 1) begin
            nstate = M_SETTLE; m_frame = 0; m_lock_cnt = 0;
          end else m_lock_cnt++;
        end
        M_SETTLE: begin
          if (fedge) begin
            if (m_frame < 3) m_frame++;
            if (m_frame >= SETTLE_N) nstate = M_RUN;
          end
        end
        default: begin
          if (m_pend && fedge) begin
            toggle = 1; m_frame = 0; nstate = M_SETTLE;
          end
        end
      endcase
    end
    if (req_edge) m_pend = 1;
    else if (toggle) m_pend = 0;
    if (toggle) m_active = !m_active;
    m_vs_prev = m_active ? src1_if.vsync : src0_if.vsync;
    m_state = nstate;
    m_sync_l = m_meta_l; m_meta_l = locked;
    m_sync_s = m_meta_s; m_meta_s = sel_req;
    if (m_active) begin
      if (nstate == M_RUN)
        exp_q.push_back(pack(src1_if.r, src1_if.g, src1_if.b, src1_if.hsync, src1_if.vsync, src1_if.blank, 1'b1, 1'b1));
      else
        exp_q.push_back(pack('0, '0, '0, src1_if.hsync, src1_if.vsync, 1'b1, 1'b1, 1'b0));
    end else begin
      if (nstate == M_RUN)
        exp_q.push_back(pack(src0_if.r, src0_if.g, src0_if.b, src0_if.hsync, src0_if.vsync, src0_if.blank, 1'b0, 1'b1));
      else
        exp_q.push_back(pack('0, '0, '0, src0_if.hsync, src0_if.vsync, 1'b1, 1'b0, 1'b0));
    end
  endtask

  // Driver
  logic drv_locked = 1'b0;
  logic drv_sel = 1'b0;
  logic drv_resetn = 1'b0;
  int   s0_pos = 0;
  int   s1_pos = 0;
  int   n_toggles = 0;
  logic last_active = 1'b0;

  task automatic gen_sources();
    s0_pos = (s0_pos + 1) % P0;
    s1_pos = (s1_pos + 1) % P1;
    src0_if.vsync = (s0_pos < 3);
    src0_if.hsync = ((s0_pos % 16) < 2);
    src0_if.blank = ((s0_pos % 16) >= 12) || (s0_pos < 6);
    src0_if.r = DEPTH'($urandom_range(0, 7));
    src0_if.g = DEPTH'($urandom_range(0, 7));
    src0_if.b = DEPTH'($urandom_range(0, 7));
    src1_if.vsync = (s1_pos >= 100) && (s1_pos < 104);
    src1_if.hsync = ((s1_pos % 20) < 3);
    src1_if.blank = ((s1_pos % 20) >= 15);
    src1_if.r = DEPTH'($urandom_range(0, 7));
    src1_if.g = DEPTH'($urandom_range(0, 7));
    src1_if.b = DEPTH'($urandom_range(0, 7));
  endtask

  // One cycle: drive at negedge, predict, compare 1 ns after the posedge.
  task automatic tick();
    logic [OW-1:0] e;
    @(negedge clk);
    resetn = drv_resetn;
    locked = drv_locked;
    sel_req = drv_sel;
    gen_sources();
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("out_vec", 32'(dut_vec()), 32'(e));
    if (active_src !== last_active) n_toggles++;
    last_active = active_src;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_sel(input int hi, input int lo);
    drv_sel = 1'b1; ticks(hi);
    drv_sel = 1'b0; ticks(lo);
  endtask

  task automatic wait_link(input string tag);
    int n;
    n = 0;
    while (link_up !== 1'b1 && n < 1000) begin tick(); n++; end
    check_val(tag, 32'(link_up), 32'd1);
  endtask

  task automatic wait_active(input string tag, input logic want);
    int n;
    n = 0;
    while (active_src !== want && n < 1000) begin tick(); n++; end
    check_val(tag, 32'(active_src), 32'(want));
  endtask

  initial begin
    int n;
    logic act_before;
    src0_if.r = '0; src0_if.g = '0; src0_if.b = '0;
    src0_if.hsync = 0; src0_if.vsync = 0; src0_if.blank = 1;
    src1_if.r = '0; src1_if.g = '0; src1_if.b = '0;
    src1_if.hsync = 0; src1_if.vsync = 0; src1_if.blank = 1;

    // Reset
    ticks(3);
    check_val("reset_vec", 32'(dut_vec()), 32'(RESET_VEC));
    check_val("reset_state", 32'(dbg_state), 32'(M_WAIT));

    // Lock, then settle, on src0
    drv_resetn = 1'b1;
    drv_locked = 1'b1;
    n = 0;
    while (link_up !== 1'b1 && n < 1000) begin tick(); n++; end
    check_val("lock_link_up", 32'(link_up), 32'd1);
    check_val("lock_min_wait", 32'(n >= 2 + LOCK_N + 1), 32'd1);
    ticks(20);
    check_val("run_state", 32'(dbg_state), 32'(M_RUN));

    // Single request switches to src1
    last_active = active_src;
    pulse_sel(18, 2);
    wait_active("switch_to_1", 1'b1);
    check_val("switch_blank", 32'(out_if.blank), 32'd1);
    check_val("switch_state", 32'(dbg_state), 32'(M_SETTLE));

    // Three requests during SETTLE collapse into one toggle
    n_toggles = 0;
    for (int k = 0; k < 3; k++) pulse_sel(18, 18);
    check_val("still_settle", 32'(dbg_state), 32'(M_SETTLE));
    wait_link("relink_src1");
    wait_active("switch_back_0", 1'b0);
    wait_link("relink_src0");
    ticks(300);
    check_val("triple_toggle_cnt", 32'(n_toggles), 32'd1);

    // One-cycle lock drop in RUN
    act_before = active_src;
    drv_locked = 1'b0;
    tick();
    drv_locked = 1'b1;
    n = 1;
    while (link_up !== 1'b0 && n < 10) begin tick(); n++; end
    check_val("lock_drop_latency", 32'(n), 32'd3);
    check_val("lock_drop_state", 32'(dbg_state), 32'(M_WAIT));
    check_val("lock_drop_blank", 32'(out_if.blank), 32'd1);
    check_val("lock_drop_active", 32'(active_src), 32'(act_before));
    wait_link("relink_after_drop");

`ifdef HDMI_SEQ_DEBOUNCE_EN
    // A short bounce is rejected; a long stable press is accepted.
    n_toggles = 0;
    pulse_sel(10, 30);
    ticks(200);
    check_val("bounce_no_toggle", 32'(n_toggles), 32'd0);
    pulse_sel(20, 2);
`else
    pulse_sel(4, 2);
`endif
    wait_active("switch_to_1_again", 1'b1);

    // Reset in the middle of SETTLE with src1 selected
    ticks(5);
    check_val("pre_reset_state", 32'(dbg_state), 32'(M_SETTLE));
    drv_resetn = 1'b0;
    tick();
    check_val("mid_reset_vec", 32'(dut_vec()), 32'(RESET_VEC));
    check_val("mid_reset_state", 32'(dbg_state), 32'(M_WAIT));
    drv_resetn = 1'b1;
    ticks(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
